pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers). It keeps a shadow scoreboard of destination registers in flight. From that it drives per-register enables and flushes, forwarding selects for the EX-stage ALU operands, and PC hold. It resolves, in a fixed priority, three conditions: data-memory wait, taken branches resolved in MEM, and load-use hazards.

## Interface
- `PERF_W`, default 16: width of the optional performance counters.
- `clk` in 1: pipeline clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_use_rs` in 1: ID instruction reads rs.
- `id_use_rt` in 1: ID instruction reads rt.
- `id_dest` in 5: destination register of the ID instruction (rd or rt, already muxed).
- `id_regwrite` in 1: ID instruction writes the register file.
- `id_memread` in 1: ID instruction is a load.
- `mem_access` in 1: instruction in MEM accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `mem_branch_taken` in 1: branch in MEM is taken (zero & branch).
- `pc_en` out 1: PC register load enable.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: pipeline register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1 each: load a bubble (all control bits 0) on the next edge.
- `fwd_a` out 2: EX operand A select.
- `fwd_b` out 2: EX operand B select.
- Select encoding for `fwd_a`/`fwd_b`: 00 = ID/EX readData, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data.
- `stall_cycles` out `PERF_W`: present only with the macro.
- `flush_events` out `PERF_W`: present only with the macro.

## Operation
- Shadow stages hold the control fields below.
  - EX: {rs, rt, dest, regwrite, memread}.
  - MEM: {dest, regwrite}.
  - WB: {dest, regwrite}.
- Each shadow stage advances exactly when its pipeline register enable is 1.
- A flush loads regwrite=0 and memread=0 into the stage it targets.
- Register 0 never causes a hazard and is never forwarded.
- Forwarding is combinational from the EX shadow against the MEM and WB shadows.
  - `fwd_a` = 10 if mem.regwrite && mem.dest == ex.rs && ex.rs != 0.
  - Otherwise `fwd_a` = 01 if wb.regwrite && wb.dest == ex.rs && ex.rs != 0.
  - Otherwise `fwd_a` = 00.
  - `fwd_b` follows the same rules using ex.rt.
  - The MEM match wins over the WB match.
- Load-use hazard (LU): ex.memread && ex.dest != 0 && ((id_use_rs && id_rs == ex.dest) || (id_use_rt && id_rt == ex.dest)).
- FSM states are RUN and MEM_WAIT.
  - RUN → MEM_WAIT when mem_access && !dmem_ready.
  - MEM_WAIT → RUN on the cycle dmem_ready=1.
- Output priority within a cycle, highest first:
  1. Memory wait (mem_access && !dmem_ready, in either state):
     - all enables 0, all flushes 0; the whole pipeline freezes.
     - LU and branch are ignored this cycle.
  2. mem_branch_taken:
     - all enables 1, pc_en=1 (PC loads the branch target).
     - if_id_flush, id_ex_flush and ex_mem_flush all 1.
     - Any LU is discarded because the ID instruction is squashed.
  3. LU:
     - pc_en=0, if_id_en=0, id_ex_flush=1 (a bubble into EX).
     - ex_mem_en=1, mem_wb_en=1.
  4. Otherwise: all enables 1, all flushes 0.
- The WB stage writes the register file before ID reads it in the same cycle, so there is no hazard check against WB for ID.

## Timing
- Reset values:
  - state RUN; all shadow fields 0.
  - enables 1, flushes 0, fwd 00; counters 0.
- Control outputs are combinational from the shadow state and current inputs, with zero-cycle latency to the pipeline registers.
- LU costs exactly 1 stall cycle. On the next edge the load moves to MEM and the dependent instruction gets `fwd`=01 one cycle later.
- A taken branch costs a 3-instruction penalty (IF, ID, EX squashed).
- MEM_WAIT may last any number of cycles, with no timeout.
- The cycle dmem_ready=1 is a normal cycle and applies priorities 2–4.
- rst asserted mid-stall or mid-MEM_WAIT returns to the reset state on that edge, regardless of other inputs.

## Configuration
- `HAZ_PERF_CNT_EN` defined: the two counters below and their ports exist.
  - `stall_cycles` increments on every cycle with pc_en=0 and !rst.
  - `flush_events` increments on every taken-branch flush.
  - Both saturate at all-ones and are cleared by rst.
- `HAZ_PERF_CNT_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: hold rst 2 cycles with random inputs.
  - Response: state RUN, enables 1, flushes 0, fwd 00; counters 0 with the macro.
- Load-use:
  - Stimulus: `lw $2` in ID (dest=2, memread), next ID `add` uses rs=2.
  - Response: exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; then `fwd_a`=01 when the add is in EX.
- EX/MEM priority:
  - Stimulus: `add $3`, `sub $3`, `or` rs=3 back-to-back.
  - Response: `fwd_a`=10 for `or`, no stall.
- Branch over LU:
  - Stimulus: mem_branch_taken=1 in the same cycle as an LU condition.
  - Response: three flushes=1, pc_en=1, no stall.
- Memory wait:
  - Stimulus: mem_access=1, dmem_ready=0 for 3 cycles with branch=1 and LU present.
  - Response: all enables 0 for 3 cycles; on the ready cycle the flush applies.
  - With the macro: stall_cycles=3.
- Reset mid-wait: rst during MEM_WAIT → RUN next cycle, enables 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage fields, memory/branch status and the pipeline
// control outputs exchanged between the datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_regwrite;
  logic             id_memread;
  logic             mem_access;
  logic             dmem_ready;
  logic             mem_branch_taken;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite, id_memread,
    output mem_access, dmem_ready, mem_branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite, id_memread,
    input  mem_access, dmem_ready, mem_branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for a 5-stage MIPS pipeline.
// Define HAZ_PERF_CNT_EN to add the stall_cycles/flush_events counters.
module pipe_hazard_ctrl #(
  parameter int unsigned PERF_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  stall_cycles,
  output logic [PERF_W-1:0]  flush_events
`endif
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

  if (PERF_W == 0) begin : g_bad_perf_w
    $error("pipe_hazard_ctrl: PERF_W must be nonzero");
  end

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             regwrite;
    logic             memread;
  } ex_sh_t;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             regwrite;
  } wr_sh_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t state;
  ex_sh_t ex_q;
  wr_sh_t mem_q;
  wr_sh_t wb_q;

  logic mem_wait;
  logic lu;
  logic br_flush;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [FWD_W-1:0] fwd_a, fwd_b;

  // Nearest producer wins; $0 is hard-wired and never forwarded.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                               input wr_sh_t m, input wr_sh_t w);
    if (src == '0)                        return FWD_RF;
    else if (m.regwrite && m.dest == src) return FWD_MEM;
    else if (w.regwrite && w.dest == src) return FWD_WB;
    else                                  return FWD_RF;
  endfunction

  assign mem_wait = hz.mem_access && !hz.dmem_ready;
  assign lu = ex_q.memread && (ex_q.dest != '0) &&
              ((hz.id_use_rs && hz.id_rs == ex_q.dest) ||
               (hz.id_use_rt && hz.id_rt == ex_q.dest));

  // Priority: memory wait > taken branch > load-use > run.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    br_flush     = 1'b0;
    if (rst) begin
      br_flush = 1'b0;
    end else if (mem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (hz.mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      br_flush     = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (mem_wait) state <= MEM_WAIT;
        MEM_WAIT: if (hz.dmem_ready) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Shadow scoreboard tracks the pipeline registers; a flush loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (id_ex_flush) begin
        ex_q <= '0;
      end else if (id_ex_en) begin
        ex_q <= '{rs: hz.id_rs, rt: hz.id_rt, dest: hz.id_dest,
                  regwrite: hz.id_regwrite, memread: hz.id_memread};
      end
      if (ex_mem_flush) begin
        mem_q <= '0;
      end else if (ex_mem_en) begin
        mem_q <= '{dest: ex_q.dest, regwrite: ex_q.regwrite};
      end
      if (mem_wb_en) begin
        wb_q <= mem_q;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
      if (br_flush && flush_events != '1) flush_events <= flush_events + PERF_W'(1);
    end
  end
`endif
endmodule
